// File: rtl/fib_sync_rx_if.sv
// fib_sync_rx_if: dual-rail input bundle plus the single-rail valid/ready
// output side of the fib_sync_rx bridge. The receiver uses the slave
// modport; the producer/consumer environment uses the master modport.
interface fib_sync_rx_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0][1:0] in;
  logic                  ack_o;
  logic [WIDTH-1:0]      data_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  proto_err_o;
  logic                  fib_err_o;

  modport slave (
    input  in,
    input  ready_i,
    output ack_o,
    output data_o,
    output valid_o,
    output proto_err_o,
    output fib_err_o
  );

  modport master (
    output in,
    output ready_i,
    input  ack_o,
    input  data_o,
    input  valid_o,
    input  proto_err_o,
    input  fib_err_o
  );
endinterface

// File: rtl/fib_sync_rx.sv
// fib_sync_rx: clocked receiver for a delay-insensitive dual-rail channel.
// Synchronizes every rail, detects codeword completion (four-phase "FP" or
// two-phase "TP"), returns the acknowledge from a flop and offers each word
// on a one-entry valid/ready slot.
// Optional Fibonacci sequence checker: define FIB_SYNC_RX_SEQ_CHECK_EN.
module fib_sync_rx #(
  parameter              ENC         = "TP",
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst,
  fib_sync_rx_if.slave bus
);

  localparam bit IS_FP = (ENC == "FP");

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_WAIT_SPACER
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0][WIDTH-1:0][1:0] sync_q, sync_d;
  logic [WIDTH-1:0][1:0] s;
  logic [WIDTH-1:0][1:0] ref_q, ref_d;
  logic [WIDTH-1:0][1:0] x;
  logic [WIDTH-1:0]      bit_ok;
  logic [WIDTH-1:0]      word;
  logic                  any_illegal;
  logic                  all_complete;
  logic                  spacer;
  logic                  go;

  logic                  ack_q, ack_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;

  // Synchronizer chain: stage 0 samples the raw rails.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = bus.in;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Per-bit decode against the phase reference (zero in FP).
  always_comb begin
    x           = '0;
    bit_ok      = '0;
    word        = '0;
    any_illegal = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      x[i]      = IS_FP ? s[i] : (s[i] ^ ref_q[i]);
      bit_ok[i] = (x[i] == 2'b01) || (x[i] == 2'b10);
      word[i]   = x[i][1];
      if (x[i] == 2'b11) begin
        any_illegal = 1'b1;
      end
    end
  end

  assign all_complete = &bit_ok;
  assign spacer       = (s == '0);
  assign go           = (state_q == ST_IDLE) && all_complete &&
                        (!valid_q || bus.ready_i);

  // Next-state and output-slot logic. The word is loaded on the edge that
  // enters CAPTURE so data/valid/ack appear SYNC_STAGES+1 edges after the
  // rails settle; CAPTURE itself is a one-cycle hold before the next phase.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    data_d  = data_q;
    valid_d = valid_q;
    ref_d   = ref_q;
    perr_d  = perr_q | any_illegal;

    if (valid_q && bus.ready_i) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_CAPTURE;
          data_d  = word;
          valid_d = 1'b1;
          ack_d   = IS_FP ? 1'b1 : ~ack_q;
          if (!IS_FP) begin
            ref_d = s;
          end
        end
      end
      ST_CAPTURE: begin
        state_d = IS_FP ? ST_WAIT_SPACER : ST_IDLE;
      end
      ST_WAIT_SPACER: begin
        if (spacer) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, slot and handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sync_q  <= '0;
      ref_q   <= '0;
      ack_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      ref_q   <= ref_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
    end
  end

  assign bus.ack_o       = ack_q;
  assign bus.data_o      = data_q;
  assign bus.valid_o     = valid_q;
  assign bus.proto_err_o = perr_q;

`ifdef FIB_SYNC_RX_SEQ_CHECK_EN
  logic [WIDTH-1:0] p1_q, p1_d;
  logic [WIDTH-1:0] p2_q, p2_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             fib_q, fib_d;
  logic [WIDTH-1:0] sum;

  assign sum = p1_q + p2_q;

  // Compare each capture with the sum of the two previous captures.
  always_comb begin
    p1_d  = p1_q;
    p2_d  = p2_q;
    cnt_d = cnt_q;
    fib_d = 1'b0;
    if (go) begin
      if ((cnt_q == 2'd2) && (word != sum)) begin
        fib_d = 1'b1;
      end
      p2_d = p1_q;
      p1_d = word;
      if (cnt_q != 2'd2) begin
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  // Sequence checker history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_q  <= '0;
      p2_q  <= '0;
      cnt_q <= '0;
      fib_q <= 1'b0;
    end else begin
      p1_q  <= p1_d;
      p2_q  <= p2_d;
      cnt_q <= cnt_d;
      fib_q <= fib_d;
    end
  end

  assign bus.fib_err_o = fib_q;
`else
  assign bus.fib_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fib_sync_rx.sv
// tb_fib_sync_rx: drives one four-phase and one two-phase receiver (WIDTH=8)
// with directed codewords and compares both against a handshake-level model
// every cycle, plus hand-computed expectations at key points.
module tb_fib_sync_rx;

`ifdef FIB_SYNC_RX_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fib_sync_rx_if #(.WIDTH(8)) if_fp ();
  fib_sync_rx_if #(.WIDTH(8)) if_tp ();

  fib_sync_rx #(.ENC("FP"), .WIDTH(8), .SYNC_STAGES(2)) dut_fp (
    .clk (clk),
    .rst (rst),
    .bus (if_fp)
  );

  fib_sync_rx #(.ENC("TP"), .WIDTH(8), .SYNC_STAGES(2)) dut_tp (
    .clk (clk),
    .rst (rst),
    .bus (if_tp)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;
  bit          cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0][1:0] fpw(input logic [7:0] w);
    logic [7:0][1:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  // ---------------- handshake-level model ----------------
  logic [7:0][1:0] m_s1  [2];
  logic [7:0][1:0] m_s2  [2];
  logic [7:0][1:0] m_ref [2];
  bit              m_ack [2];
  logic [7:0]      m_data[2];
  bit              m_valid[2];
  bit              m_perr[2];
  bit              m_fib [2];
  bit              m_just[2];
  logic [7:0]      hist_fp[$];
  logic [7:0]      hist_tp[$];

  always @(posedge clk or posedge rst) begin
    logic [7:0][1:0] sv, xv, cur_in;
    logic [7:0]      w, sum;
    bit              fp, comp, ill, cap, rdy, viol;
    int              n;
    if (rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        m_s1[ch] = '0; m_s2[ch] = '0; m_ref[ch] = '0;
        m_ack[ch] = 0; m_data[ch] = '0; m_valid[ch] = 0;
        m_perr[ch] = 0; m_fib[ch] = 0; m_just[ch] = 0;
      end
      hist_fp.delete();
      hist_tp.delete();
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        fp     = (ch == 0);
        cur_in = fp ? if_fp.in : if_tp.in;
        rdy    = fp ? if_fp.ready_i : if_tp.ready_i;
        sv     = m_s2[ch];
        comp   = 1; ill = 0;
        for (int i = 0; i < 8; i++) begin
          xv[i] = fp ? sv[i] : (sv[i] ^ m_ref[ch][i]);
          w[i]  = xv[i][1];
          if ($countones(xv[i]) != 1) comp = 0;
          if ($countones(xv[i]) == 2) ill = 1;
        end
        m_fib[ch] = 0;
        if (ill) m_perr[ch] = 1;
        cap = comp && !m_just[ch] && (!fp || !m_ack[ch]) && (!m_valid[ch] || rdy);
        if (cap) begin
          m_data[ch]  = w;
          m_valid[ch] = 1;
          m_ack[ch]   = fp ? 1'b1 : !m_ack[ch];
          if (!fp) m_ref[ch] = sv;
          if (fp) begin
            hist_fp.push_back(w); n = hist_fp.size();
            sum  = (n >= 3) ? hist_fp[n-2] + hist_fp[n-3] : 8'd0;
          end else begin
            hist_tp.push_back(w); n = hist_tp.size();
            sum  = (n >= 3) ? hist_tp[n-2] + hist_tp[n-3] : 8'd0;
          end
          viol = (n >= 3) && (w != sum);
          m_fib[ch] = SEQ_EN && viol;
        end else begin
          if (m_valid[ch] && rdy) m_valid[ch] = 0;
          if (fp && m_ack[ch] && !m_just[ch] && sv == '0) m_ack[ch] = 0;
        end
        m_just[ch] = cap;
        m_s2[ch]   = m_s1[ch];
        m_s1[ch]   = cur_in;
      end
    end
  end

  // Cycle-by-cycle comparison of both receivers against the model.
  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      check("fp.ack",   if_fp.ack_o,       m_ack[0]);
      check("fp.data",  if_fp.data_o,      m_data[0]);
      check("fp.valid", if_fp.valid_o,     m_valid[0]);
      check("fp.perr",  if_fp.proto_err_o, m_perr[0]);
      check("fp.fib",   if_fp.fib_err_o,   m_fib[0]);
      check("tp.ack",   if_tp.ack_o,       m_ack[1]);
      check("tp.data",  if_tp.data_o,      m_data[1]);
      check("tp.valid", if_tp.valid_o,     m_valid[1]);
      check("tp.perr",  if_tp.proto_err_o, m_perr[1]);
      check("tp.fib",   if_tp.fib_err_o,   m_fib[1]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fp_ack(input bit val, input int unsigned max, input string name);
    int unsigned k = 0;
    while (if_fp.ack_o !== val && k < max) begin
      @(negedge clk);
      k++;
    end
    check(name, if_fp.ack_o, val);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [7:0]      tp_words [6] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd9};
  bit              tp_acks  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0][1:0] tp_cur;
  logic [7:0][1:0] bad;
  bit              prev_ack;

  initial begin
    rst = 1'b1;
    if_fp.in = '0; if_tp.in = '0;
    if_fp.ready_i = 1'b1; if_tp.ready_i = 1'b1;
    tick(3);
    check("rst.fp.ack",   if_fp.ack_o, 1'b0);
    check("rst.fp.data",  if_fp.data_o, 8'h00);
    check("rst.fp.valid", if_fp.valid_o, 1'b0);
    check("rst.fp.perr",  if_fp.proto_err_o, 1'b0);
    check("rst.fp.fib",   if_fp.fib_err_o, 1'b0);
    check("rst.tp.ack",   if_tp.ack_o, 1'b0);
    check("rst.tp.data",  if_tp.data_o, 8'h00);
    check("rst.tp.valid", if_tp.valid_o, 1'b0);
    rst = 1'b0;
    cmp_en = 1'b1;
    tick(1);

    // Two-phase: Fibonacci words, the last breaking the sequence.
    tp_cur   = '0;
    prev_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tp_cur   = tp_cur ^ fpw(tp_words[i]);
      if_tp.in = tp_cur;
      tick(2);
      check("tp.ack_hold", if_tp.ack_o, prev_ack);
      tick(1);
      check("tp.word",  if_tp.data_o, tp_words[i]);
      check("tp.valid", if_tp.valid_o, 1'b1);
      check("tp.ackseq", if_tp.ack_o, tp_acks[i]);
      check("tp.fibpulse", if_tp.fib_err_o, (i == 5) && SEQ_EN);
      prev_ack = tp_acks[i];
    end
    tick(1);
    check("tp.fib_one_cycle", if_tp.fib_err_o, 1'b0);

    // Four-phase: 0x05 then return to zero.
    if_fp.in = fpw(8'h05);
    tick(2);
    check("fp.latency_ack", if_fp.ack_o, 1'b0);
    tick(1);
    check("fp.w5.data",  if_fp.data_o, 8'h05);
    check("fp.w5.valid", if_fp.valid_o, 1'b1);
    check("fp.w5.ack",   if_fp.ack_o, 1'b1);
    if_fp.in = '0;
    tick(2);
    check("fp.rtz_hold", if_fp.ack_o, 1'b1);
    tick(1);
    check("fp.rtz_clear", if_fp.ack_o, 1'b0);

    // Backpressure: second word waits for the slot.
    if_fp.ready_i = 1'b0;
    if_fp.in = fpw(8'h03);
    tick(3);
    check("bp.w3.data", if_fp.data_o, 8'h03);
    check("bp.w3.ack",  if_fp.ack_o, 1'b1);
    if_fp.in = '0;
    wait_fp_ack(1'b0, 10, "bp.spacer_ack");
    if_fp.in = fpw(8'h04);
    tick(6);
    check("bp.stall.ack",   if_fp.ack_o, 1'b0);
    check("bp.stall.data",  if_fp.data_o, 8'h03);
    check("bp.stall.valid", if_fp.valid_o, 1'b1);
    if_fp.ready_i = 1'b1;
    tick(1);
    check("bp.w4.data",  if_fp.data_o, 8'h04);
    check("bp.w4.valid", if_fp.valid_o, 1'b1);
    check("bp.w4.ack",   if_fp.ack_o, 1'b1);
    if_fp.in = '0;
    wait_fp_ack(1'b0, 10, "bp.w4.rtz");

    // Illegal codeword: bit 2 both rails high.
    bad = fpw(8'h00);
    bad[2] = 2'b11;
    if_fp.in = bad;
    tick(4);
    check("ill.perr",  if_fp.proto_err_o, 1'b1);
    check("ill.ack",   if_fp.ack_o, 1'b0);
    check("ill.valid", if_fp.valid_o, 1'b0);
    if_fp.in = '0;
    tick(3);
    check("ill.sticky", if_fp.proto_err_o, 1'b1);

    // Reset while waiting for the spacer.
    if_fp.ready_i = 1'b0;
    if_fp.in = fpw(8'h06);
    tick(3);
    check("rs.w6.ack", if_fp.ack_o, 1'b1);
    tick(1);
    #2;
    rst = 1'b1;
    if_fp.in = '0;
    #1;
    check("rs.async.ack",   if_fp.ack_o, 1'b0);
    check("rs.async.valid", if_fp.valid_o, 1'b0);
    check("rs.async.perr",  if_fp.proto_err_o, 1'b0);
    tick(1);
    #3;
    rst = 1'b0;
    @(negedge clk);
    if_fp.in = fpw(8'h07);
    tick(2);
    check("rs.w7.early", if_fp.ack_o, 1'b0);
    tick(1);
    check("rs.w7.data",  if_fp.data_o, 8'h07);
    check("rs.w7.valid", if_fp.valid_o, 1'b1);
    check("rs.w7.ack",   if_fp.ack_o, 1'b1);
    if_fp.in = '0;
    wait_fp_ack(1'b0, 10, "rs.w7.rtz");
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
